// File: rtl/mc_pkg.sv
// mc_pkg: state, mux-select and opcode encodings shared by the multicycle sequencer.
package mc_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;
  typedef enum logic [1:0] {NPC_PC4 = 2'b00, NPC_BR = 2'b01, NPC_JAL = 2'b10, NPC_JR = 2'b11} npc_e;
  typedef enum logic [1:0] {WR_RT = 2'b00, WR_RD = 2'b01, WR_RA = 2'b10} wr_sel_e;
  typedef enum logic [1:0] {WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC4 = 2'b10} wd_sel_e;
  typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10} ext_e;
  typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010} alu_e;
  localparam logic [1:0] MT_WORD = 2'b00;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  typedef struct packed {
    logic addu, subu, jr, ori, lui, lw, sw, beq, bltz, jal;
  } cls_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: maps opcode/funct to a one-hot instruction class plus an illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       bad
);
  logic rtype;
  assign rtype    = opcode == OP_RTYPE;
  assign cls.addu = rtype && funct == FN_ADDU;
  assign cls.subu = rtype && funct == FN_SUBU;
  assign cls.jr   = rtype && funct == FN_JR;
  assign cls.ori  = opcode == OP_ORI;
  assign cls.lui  = opcode == OP_LUI;
  assign cls.lw   = opcode == OP_LW;
  assign cls.sw   = opcode == OP_SW;
  assign cls.beq  = opcode == OP_BEQ;
  assign cls.bltz = opcode == OP_BLTZ;
  assign cls.jal  = opcode == OP_JAL;
  assign bad      = ~|cls;
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle MIPS-subset control FSM with sticky illegal flag.
// Optional perf counters are built only when MC_SEQUENCER_PERF_EN is defined.
module mc_sequencer
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        branch,
  input  logic        mem_ready,
  output logic        pc_wr,
  output logic        ir_wr,
  output logic [1:0]  npc_op,
  output logic [1:0]  wr_sel,
  output logic [1:0]  wd_sel,
  output logic        rf_wr,
  output logic [1:0]  ext_op,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [1:0]  mem_type,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);
  state_e st, nxt;
  cls_t cls;
  logic bad, ill_q, set_ill, alu_st;
  logic pc_wr_c, ir_wr_c, rf_wr_c, dm_rd_c, dm_wr_c;
  mc_decode u_dec (.opcode(opcode), .funct(funct), .cls(cls), .bad(bad));
  // ALU controls only follow the opcode once the instruction reaches the datapath
  assign alu_st  = st == S_EXEC || st == S_MEM || st == S_WB;
  assign alu_src = alu_st & (cls.ori | cls.lui | cls.lw | cls.sw);
  assign ext_op  = !alu_st ? EXT_ZERO : cls.lui ? EXT_LUI : (cls.lw | cls.sw) ? EXT_SIGN : EXT_ZERO;
  assign alu_op  = !alu_st ? ALU_ADD : (cls.ori | cls.lui) ? ALU_OR : cls.beq ? ALU_SUB : ALU_ADD;
  assign mem_type = MT_WORD;
  always_comb begin
    nxt = S_FETCH;
    pc_wr_c = 1'b0;
    ir_wr_c = 1'b0;
    rf_wr_c = 1'b0;
    dm_rd_c = 1'b0;
    dm_wr_c = 1'b0;
    set_ill = 1'b0;
    npc_op = NPC_PC4;
    wr_sel = WR_RT;
    wd_sel = WD_ALU;
    case (st)
      S_FETCH: begin
        ir_wr_c = mem_ready;
        nxt = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        pc_wr_c = cls.jal | cls.jr | bad;
        rf_wr_c = cls.jal;
        set_ill = bad;
        npc_op = cls.jal ? NPC_JAL : cls.jr ? NPC_JR : NPC_PC4;
        wr_sel = cls.jal ? WR_RA : WR_RT;
        wd_sel = cls.jal ? WD_PC4 : WD_ALU;
        nxt = (cls.jal | cls.jr | bad) ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        pc_wr_c = cls.beq | cls.bltz;
        npc_op = (cls.beq & zero) | (cls.bltz & branch) ? NPC_BR : NPC_PC4;
        nxt = (cls.lw | cls.sw) ? S_MEM : (cls.beq | cls.bltz) ? S_FETCH : S_WB;
      end
      S_MEM: begin
        dm_rd_c = cls.lw;
        dm_wr_c = ~cls.lw;
        pc_wr_c = ~cls.lw & mem_ready;
        nxt = !mem_ready ? S_MEM : cls.lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_wr_c = 1'b1;
        pc_wr_c = 1'b1;
        wr_sel = (cls.addu | cls.subu) ? WR_RD : WR_RT;
        wd_sel = cls.lw ? WD_MEM : WD_ALU;
      end
      default: nxt = S_FETCH;
    endcase
  end
  // strobes are masked by reset so an asserted reset kills them within the cycle
  assign pc_wr = pc_wr_c & reset;
  assign ir_wr = ir_wr_c & reset;
  assign rf_wr = rf_wr_c & reset;
  assign dm_rd = dm_rd_c & reset;
  assign dm_wr = dm_wr_c & reset;
  assign state = st;
  assign illegal = ill_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= S_FETCH;
      ill_q <= 1'b0;
    end else begin
      st <= nxt;
      ill_q <= ill_q | set_ill;
    end
`ifdef MC_SEQUENCER_PERF_EN
  logic [31:0] cyc_q, ins_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      ins_q <= ins_q + 32'(pc_wr_c);
    end
  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif
endmodule
